multibyte_add_seq: RTL and testbench

Sequencing stage placed directly upstream of the 8-bit ripple carry adder. It accepts multi-precision operands one byte per transfer, least significant byte first, and drives the adder's x, y and carry_in. It captures the adder's sum and carry_out into a registered output stream, chaining carry across bytes. The result is an NUM_BYTES-byte add or subtract computed on a single 8-bit adder.

---
 rtl/multibyte_add_seq.sv | 121 ++++++++++++
 tb/tb_multibyte_add_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/multibyte_add_seq.sv
// Byte-serial sequencer that drives an external 8-bit adder to build NUM_BYTES-wide add/sub.
// Optional out_zero flag is enabled with `define MULTIBYTE_ADD_ZERO_FLAG_EN.
module multibyte_add_seq #(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_sub,
  output logic [7:0] add_x,
  output logic [7:0] add_y,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       out_cout,
`ifdef MULTIBYTE_ADD_ZERO_FLAG_EN
  output logic       out_zero,
`endif
  output logic       out_ovf
);

  localparam int unsigned CNT_W = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] MID_END_CNT = CNT_W'(NUM_BYTES - 2);

  typedef enum logic [1:0] {FIRST, MID, LAST} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] byte_cnt;
  logic             carry_reg;
  logic             sub_reg;
  logic             sub_eff;
  logic             accept;
  logic             ovf_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign add_x    = in_a;
  assign add_y    = in_b ^ {8{sub_eff}};
  assign ovf_next = (in_a[7] == add_y[7]) && (add_sum[7] != in_a[7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FIRST;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    sub_eff    = sub_reg;
    add_cin    = carry_reg;
    case (state)
      FIRST: begin
        // byte 0 takes the operation directly from the input; later bytes use the latched copy
        sub_eff = in_sub;
        add_cin = in_sub;
        if (accept) next_state = (NUM_BYTES == 2) ? LAST : MID;
      end
      MID:  if (accept && byte_cnt == MID_END_CNT) next_state = LAST;
      LAST: if (accept) next_state = FIRST;
      default: next_state = FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      if (state == FIRST) sub_reg <= in_sub;
      if (state == LAST) begin
        out_last  <= 1'b1;
        out_cout  <= add_cout;
        out_ovf   <= ovf_next;
        byte_cnt  <= '0;
        carry_reg <= 1'b0;
      end else begin
        out_last  <= 1'b0;
        out_cout  <= 1'b0;
        out_ovf   <= 1'b0;
        byte_cnt  <= byte_cnt + 1'b1;
        carry_reg <= add_cout;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MULTIBYTE_ADD_ZERO_FLAG_EN
  logic nz_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_reg   <= 1'b0;
      out_zero <= 1'b0;
    end else if (accept) begin
      if (state == LAST) begin
        out_zero <= ~(nz_reg | (|add_sum));
        nz_reg   <= 1'b0;
      end else begin
        out_zero <= 1'b0;
        nz_reg   <= nz_reg | (|add_sum);
      end
    end
  end
`endif

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq with a behavioural 8-bit adder on the add_* side.
// Checks out_zero too when MULTIBYTE_ADD_ZERO_FLAG_EN is defined.
module tb_multibyte_add_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_sub = 1'b0;
  logic [7:0] add_x, add_y, add_sum;
  logic       add_cin, add_cout;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic       out_last, out_cout, out_ovf;
`ifdef MULTIBYTE_ADD_ZERO_FLAG_EN
  logic       out_zero;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_cin};

  multibyte_add_seq #(.NUM_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last), .out_cout(out_cout),
`ifdef MULTIBYTE_ADD_ZERO_FLAG_EN
    .out_zero(out_zero),
`endif
    .out_ovf(out_ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sends the first nbytes of a word back-to-back with out_ready=1; optional idle cycle before byte 2.
  task automatic run_vec(input vec_t v, input int nbytes, input bit idle);
    logic       carry_m;
    logic [8:0] s9;
    logic [7:0] yb;
    carry_m = v.sub;
    for (int i = 0; i < nbytes; i++) begin
      if (idle && i == 2) begin
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = v.a[8*i +: 8];
      in_b     = v.b[8*i +: 8];
      in_sub   = (i == 0) ? v.sub : ~v.sub;
      #1;
      chk("in_ready", {31'd0, in_ready}, 32'd1);
      chk("add_cin", {31'd0, add_cin}, {31'd0, carry_m});
      yb      = v.b[8*i +: 8] ^ {8{v.sub}};
      s9      = {1'b0, v.a[8*i +: 8]} + {1'b0, yb} + {8'd0, carry_m};
      carry_m = s9[8];
      @(posedge clk); #1;
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("out_sum", {24'd0, out_sum}, {24'd0, v.res[8*i +: 8]});
      chk("out_last", {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
      chk("out_cout", {31'd0, out_cout}, (i == 3) ? {31'd0, v.cout} : 32'd0);
      chk("out_ovf", {31'd0, out_ovf}, (i == 3) ? {31'd0, v.ovf} : 32'd0);
`ifdef MULTIBYTE_ADD_ZERO_FLAG_EN
      chk("out_zero", {31'd0, out_zero}, (i == 3) ? {31'd0, v.zero} : 32'd0);
`endif
    end
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t bp;
    vec_t rv;
    //           a             b             sub   res           cout  ovf   zero
    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{32'h0102_0304, 32'h1020_3040, 1'b0, 32'h1122_3344, 1'b0, 1'b0, 1'b0};

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) run_vec(vecs[v], 4, (v % 2) == 1);

    // Backpressure: stall the output for 3 cycles while byte 1 (0x01) is held.
    bp = vecs[0];
    run_vec(bp, 2, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = bp.a[23:16];
    in_b      = bp.b[23:16];
    in_sub    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_sum", {24'd0, out_sum}, 32'h01);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_add_cin", {31'd0, add_cin}, 32'd0);
    @(posedge clk); #1;
    chk("bp_byte2", {24'd0, out_sum}, 32'h00);
    chk("bp_byte2_last", {31'd0, out_last}, 32'd0);
    @(negedge clk);
    in_a   = bp.a[31:24];
    in_b   = bp.b[31:24];
    in_sub = 1'b0;
    @(posedge clk); #1;
    chk("bp_byte3", {24'd0, out_sum}, 32'h00);
    chk("bp_byte3_last", {31'd0, out_last}, 32'd1);
    chk("bp_byte3_cout", {31'd0, out_cout}, 32'd0);
    in_valid = 1'b0;

    // Reset mid-word after two bytes that leave a carry pending.
    run_vec(vecs[1], 2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_sum", {24'd0, out_sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
    run_vec(rv, 4, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("final_out_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
